// File: rtl/flash_ctrl_pkg.sv
// Shared NAND flash controller definitions: read sequencer state encoding,
// bad-block lookup result codes and low-level page read status codes.
package flash_ctrl_pkg;

  typedef enum logic [3:0] {
    RS_PWRUP   = 4'd0,
    RS_IDLE    = 4'd1,
    RS_START   = 4'd2,
    RS_CHKBAD  = 4'd3,
    RS_ISSUE   = 4'd4,
    RS_SKIPBLK = 4'd5,
    RS_WAIT    = 4'd6,
    RS_ADVANCE = 4'd7,
    RS_NEXTCHK = 4'd8,
    RS_DONE    = 4'd9,
    RS_RETRY   = 4'd10,
    RS_ERR     = 4'd11,
    RS_RELEASE = 4'd13
  } read_state_t;

  localparam logic [1:0] ROW_PENDING = 2'd0;
  localparam logic [1:0] ROW_GOOD    = 2'd1;
  localparam logic [1:0] ROW_BAD     = 2'd2;

  localparam logic [1:0] STAT_OK       = 2'd1;
  localparam logic [1:0] STAT_ECC_FAIL = 2'd2;

endpackage

// File: rtl/read_flash_state_control.sv
// Read sequencer for the NAND flash controller. Walks pages_left rows starting
// at the externally maintained row address, checks each new block against the
// bad-block lookup, skips bad blocks and reports done or a sticky failure.
// Optional ECC re-read support is built when READ_RETRY_EN is defined;
// otherwise an uncorrectable page goes straight to ERR.
//
// state   | meaning
// PWRUP   | post-reset, one cycle
// IDLE    | waiting for en_read
// START   | latch page count (unless returning from a block skip)
// CHKBAD  | wait one cycle for lookup, then act on good/bad/pending
// ISSUE   | rd_start pulse
// SKIPBLK | block_skip pulse, back to START keeping the count
// WAIT    | waiting for rd_done from the low-level FSM
// ADVANCE | addr_inc pulse, one page consumed
// NEXTCHK | block boundary crossed -> CHKBAD, else ISSUE
// DONE    | end_read pulse
// RETRY   | ECC failure handling
// ERR     | read_fail held until en_read drops
// RELEASE | one cycle before returning to IDLE
module read_flash_state_control
  import flash_ctrl_pkg::*;
#(
  parameter int PAGE_BITS = 7,
  parameter int MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_read,
  input  logic [7:0]  page_count,
  input  logic [23:0] read_addr_row,
  input  logic [1:0]  read_addr_row_error,
  input  logic        rd_done,
  input  logic [1:0]  read_status,
  output logic        rd_start,
  output logic        addr_inc,
  output logic        block_skip,
  output logic [3:0]  read_state,
  output logic        end_read,
  output logic        read_fail
);

  if (MAX_RETRY < 1 || MAX_RETRY > 3) begin : g_bad_max_retry
    $error("MAX_RETRY must be in 1..3");
  end

  read_state_t state, state_next;
  logic [7:0]  pages_left, pages_left_next;
  logic        wait_flag, wait_next;
  logic        skip_flag, skip_next;
  logic        unused_row;

`ifdef READ_RETRY_EN
  // One bit wider than MAX_RETRY so the count can exceed it without wrapping.
  logic [2:0]  retry_cnt, retry_next;
`endif

  // Only the page index within the block matters here.
  assign unused_row = ^read_addr_row[23:PAGE_BITS];
  assign read_state = state;

  // Next-state and internal counter logic.
  always_comb begin
    state_next      = state;
    pages_left_next = pages_left;
    wait_next       = wait_flag;
    skip_next       = skip_flag;
`ifdef READ_RETRY_EN
    retry_next      = retry_cnt;
`endif
    case (state)
      RS_PWRUP: state_next = RS_IDLE;
      RS_IDLE:  if (en_read) state_next = RS_START;
      RS_START: begin
        if (!skip_flag) pages_left_next = (page_count == 8'd0) ? 8'd1 : page_count;
        skip_next = 1'b0;
`ifdef READ_RETRY_EN
        retry_next = '0;
`endif
        state_next = RS_CHKBAD;
      end
      RS_CHKBAD: begin
        // Lookup trails the address by a clock: first cycle is always a wait.
        if (!wait_flag) begin
          wait_next = 1'b1;
        end else if (read_addr_row_error == ROW_GOOD) begin
          wait_next  = 1'b0;
          state_next = RS_ISSUE;
        end else if (read_addr_row_error == ROW_BAD) begin
          wait_next  = 1'b0;
          state_next = RS_SKIPBLK;
        end
      end
      RS_SKIPBLK: begin
        skip_next  = 1'b1;
        state_next = RS_START;
      end
      RS_ISSUE: state_next = RS_WAIT;
      RS_WAIT: begin
        if (rd_done && read_status == STAT_OK)            state_next = RS_ADVANCE;
        else if (rd_done && read_status == STAT_ECC_FAIL) state_next = RS_RETRY;
      end
      RS_ADVANCE: begin
        if (pages_left != 8'd0) pages_left_next = pages_left - 8'd1;
`ifdef READ_RETRY_EN
        retry_next = '0;
`endif
        state_next = (pages_left <= 8'd1) ? RS_DONE : RS_NEXTCHK;
      end
      RS_NEXTCHK: begin
        if (read_addr_row[PAGE_BITS-1:0] == '0) state_next = RS_CHKBAD;
        else                                    state_next = RS_ISSUE;
      end
      RS_RETRY: begin
`ifdef READ_RETRY_EN
        retry_next = retry_cnt + 3'd1;
        if (retry_next <= 3'(MAX_RETRY)) state_next = RS_ISSUE;
        else                             state_next = RS_ERR;
`else
        state_next = RS_ERR;
`endif
      end
      RS_ERR:     if (!en_read) state_next = RS_IDLE;
      RS_DONE:    state_next = RS_RELEASE;
      RS_RELEASE: state_next = RS_IDLE;
      default:    state_next = RS_PWRUP;
    endcase
  end

  // State and internal counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RS_PWRUP;
      pages_left <= 8'd0;
      wait_flag  <= 1'b0;
      skip_flag  <= 1'b0;
`ifdef READ_RETRY_EN
      retry_cnt  <= '0;
`endif
    end else begin
      state      <= state_next;
      pages_left <= pages_left_next;
      wait_flag  <= wait_next;
      skip_flag  <= skip_next;
`ifdef READ_RETRY_EN
      retry_cnt  <= retry_next;
`endif
    end
  end

  // Registered outputs decoded from the upcoming state so each pulse lines up with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_start   <= 1'b0;
      addr_inc   <= 1'b0;
      block_skip <= 1'b0;
      end_read   <= 1'b0;
      read_fail  <= 1'b0;
    end else begin
      rd_start   <= (state_next == RS_ISSUE);
      addr_inc   <= (state_next == RS_ADVANCE);
      block_skip <= (state_next == RS_SKIPBLK);
      end_read   <= (state_next == RS_DONE);
      if (state == RS_IDLE && state_next == RS_START) read_fail <= 1'b0;
      else if (state_next == RS_ERR)                  read_fail <= 1'b1;
    end
  end

endmodule
